// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling swap pass over an external 256-byte S memory.
// It assumes S starts as the identity permutation and performs one read-read-write-write swap per index.
module ksa_shuffle #(
   parameter int KEY_BYTES = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   output logic [7:0]             mem_addr,
   output logic [7:0]             mem_wrdata,
   output logic                   mem_wren,
   input  logic [7:0]             mem_rddata,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      IDLE, READ_I, CAPT_I, READ_J, CAPT_J, WRITE_I, WRITE_J
   } state_t;

   localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   state_t        state_q, state_d;
   logic [7:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
   logic [KW-1:0] kidx_q, kidx_d;
   logic          done_q, done_d;
   logic [7:0]    keyByte;

   // kidx tracks i mod KEY_BYTES incrementally so no divider is needed
   always_comb begin
      keyByte = '0;
      for (int k = 0; k < KEY_BYTES; k++) begin
         if (kidx_q == KW'(k)) keyByte = secret_key[8*(KEY_BYTES-1-k) +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         kidx_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         kidx_q  <= kidx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      kidx_d  = kidx_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               kidx_d  = '0;
               done_d  = 1'b0;
               state_d = READ_I;
            end
         end
         READ_I:  state_d = CAPT_I;
         CAPT_I: begin
            si_d    = mem_rddata;
            j_d     = j_q + mem_rddata + keyByte;
            state_d = READ_J;
         end
         READ_J:  state_d = CAPT_J;
         CAPT_J: begin
            sj_d    = mem_rddata;
            state_d = WRITE_I;
         end
         WRITE_I: state_d = WRITE_J;
         WRITE_J: begin
            i_d    = i_q + 8'd1;
            kidx_d = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
            // The 255->0 wrap of i ends the pass
            if (i_q == 8'hFF) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = READ_I;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_addr   = '0;
      mem_wrdata = '0;
      mem_wren   = 1'b0;
      case (state_q)
         READ_I:  mem_addr = i_q;
         READ_J:  mem_addr = j_q;
         WRITE_I: begin
            mem_addr   = i_q;
            mem_wrdata = sj_q;
            mem_wren   = 1'b1;
         end
         WRITE_J: begin
            mem_addr   = j_q;
            mem_wrdata = si_q;
            mem_wren   = 1'b1;
         end
         default: ;
      endcase
      busy = (state_q != IDLE);
      done = done_q;
   end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Directed bench for ksa_shuffle: registered-read S memory model, write log and behavioural RC4 KSA golden model.
module tb_ksa_shuffle;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [23:0] secretKey = '0;
   logic [7:0]  memAddr, memWrdata, memRddata;
   logic        memWren, busy, done;

   logic [7:0]  mem [256];
   logic [7:0]  gold [256];
   logic [7:0]  logAddr [$];
   logic [7:0]  logData [$];
   logic [7:0]  refAddr [$];
   logic [7:0]  refData [$];
   logic        fillReq = 1'b0;
   int          assertCount = 0;
   int          failCount = 0;
   int          cycles, mism, logLen;
   logic        busyLow;

   ksa_shuffle #(.KEY_BYTES(3)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secretKey),
      .mem_addr(memAddr), .mem_wrdata(memWrdata), .mem_wren(memWren),
      .mem_rddata(memRddata), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Synchronous S memory with one-cycle read latency, plus a log of every write
   always @(posedge clk) begin
      if (fillReq) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (memWren) begin
         mem[memAddr] <= memWrdata;
         logAddr.push_back(memAddr);
         logData.push_back(memWrdata);
      end
      memRddata <= mem[memAddr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic void goldKsa(input logic [23:0] key);
      logic [7:0] j, t;
      j = '0;
      for (int k = 0; k < 256; k++) gold[k] = 8'(k);
      for (int i = 0; i < 256; i++) begin
         j = j + gold[i] + key[8*(2-(i%3)) +: 8];
         t = gold[i];
         gold[i] = gold[j];
         gold[j] = t;
      end
   endfunction

   task automatic fillIdentity();
      @(negedge clk) fillReq = 1'b1;
      @(negedge clk) fillReq = 1'b0;
      logAddr.delete();
      logData.delete();
   endtask

   task automatic applyStimulus(input logic [23:0] key, input logic hold);
      secretKey = key;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
   endtask

   // Counts edges after the accepting edge until done; optional start pulses mid-pass
   task automatic waitDone(input logic pulse, output int n, output logic sawBusyLow);
      n = 0;
      sawBusyLow = 1'b0;
      while (n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
         if (!busy) sawBusyLow = 1'b1;
         if (pulse) start = (n == 10 || n == 200 || n == 900);
      end
      if (pulse) start = 1'b0;
   endtask

   initial begin
      #3;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_wren", 32'(memWren), 32'd0);
      checkOutput("reset_addr", 32'(memAddr), 32'd0);
      checkOutput("reset_wrdata", 32'(memWrdata), 32'd0);
      @(negedge clk) reset_n = 1'b1;

      // Key 010203: first swap exchanges S[0] and S[1]
      fillIdentity();
      applyStimulus(24'h010203, 1'b0);
      waitDone(1'b0, cycles, busyLow);
      checkOutput("k010203_done_cycles", 32'(cycles), 32'd1536);
      checkOutput("k010203_w0", {logAddr[0], logData[0]}, {8'd0, 8'd1});
      checkOutput("k010203_w1", {logAddr[1], logData[1]}, {8'd1, 8'd0});
      checkOutput("k010203_busy_drop", 32'(busyLow), 32'd0);

      // Zero key: i=j on iterations 0 and 1, then 2<->3
      fillIdentity();
      applyStimulus(24'h000000, 1'b0);
      waitDone(1'b0, cycles, busyLow);
      checkOutput("k0_log_len", 32'(logAddr.size()), 32'd512);
      checkOutput("k0_w0", {logAddr[0], logData[0]}, {8'd0, 8'd0});
      checkOutput("k0_w1", {logAddr[1], logData[1]}, {8'd0, 8'd0});
      checkOutput("k0_w4", {logAddr[4], logData[4]}, {8'd2, 8'd3});
      checkOutput("k0_w5", {logAddr[5], logData[5]}, {8'd3, 8'd2});

      // Key 000249 full pass against the golden model
      fillIdentity();
      applyStimulus(24'h000249, 1'b0);
      waitDone(1'b0, cycles, busyLow);
      checkOutput("k249_done_cycles", 32'(cycles), 32'd1536);
      checkOutput("k249_busy_drop", 32'(busyLow), 32'd0);
      checkOutput("k249_busy_after", 32'(busy), 32'd0);
      goldKsa(24'h000249);
      @(negedge clk);
      mism = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) mism++;
      checkOutput("k249_golden_mismatches", 32'(mism), 32'd0);
      refAddr = logAddr;
      refData = logData;

      // Start pulses during the pass must be ignored
      fillIdentity();
      applyStimulus(24'h000249, 1'b0);
      waitDone(1'b1, cycles, busyLow);
      checkOutput("pulse_done_cycles", 32'(cycles), 32'd1536);
      checkOutput("pulse_log_len", 32'(logAddr.size()), 32'(refAddr.size()));
      mism = 0;
      for (int k = 0; k < logAddr.size() && k < refAddr.size(); k++)
         if (logAddr[k] !== refAddr[k] || logData[k] !== refData[k]) mism++;
      checkOutput("pulse_log_diffs", 32'(mism), 32'd0);

      // Asynchronous reset in the middle of the first WRITE_I
      fillIdentity();
      applyStimulus(24'h010203, 1'b0);
      cycles = 0;
      while (!memWren && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("ar_reached_write", 32'(memWren), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("ar_wren", 32'(memWren), 32'd0);
      checkOutput("ar_busy", 32'(busy), 32'd0);
      checkOutput("ar_done", 32'(done), 32'd0);
      logLen = logAddr.size();
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ar_no_write", 32'(logAddr.size()), 32'(logLen));
      checkOutput("ar_stays_idle", 32'(busy), 32'd0);

      fillIdentity();
      applyStimulus(24'h010203, 1'b0);
      cycles = 0;
      while (logAddr.size() < 2 && cycles < 20) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("ar_restart_len", 32'(logAddr.size() >= 2), 32'd1);
      if (logAddr.size() >= 2) begin
         checkOutput("ar_restart_w0", {logAddr[0], logData[0]}, {8'd0, 8'd1});
         checkOutput("ar_restart_w1", {logAddr[1], logData[1]}, {8'd1, 8'd0});
      end
      @(negedge clk) reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;

      // Start held high: second pass begins on the edge after done rises
      fillIdentity();
      applyStimulus(24'h000249, 1'b1);
      waitDone(1'b0, cycles, busyLow);
      checkOutput("hold_done_cycles", 32'(cycles), 32'd1536);
      checkOutput("hold_done_high", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("hold_done_cleared", 32'(done), 32'd0);
      checkOutput("hold_busy_again", 32'(busy), 32'd1);
      start = 1'b0;
      @(negedge clk) reset_n = 1'b0;
      #1;
      checkOutput("final_reset_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
